decode_buffer: RTL and testbench
================================

Name: decode_buffer

Overview:
- Parametrised instruction buffer between fetch and decode, with a valid/ready handshake on both sides.
- Each instruction is pre-decoded on entry and stored as {inst, pc, illegal, cflow, serial}.
- Enforces serialisation: CSR, ECALL/EBREAK/MRET and FENCE.I issue only into an empty pipeline, and nothing younger issues until they retire.
- Supports a single-cycle flush for redirects and traps.

Parameters:
- XLEN, 32, width of the PC field.
- DEPTH, 4, number of entries; must be a power of 2 and at least 2.
- SERIALIZE, 1, 1 enables the serialisation FSM; 0 makes serial instructions issue like any other.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  buffer accepts an instruction this cycle.
- in_inst  in  32  fetched instruction word.
- in_pc  in  XLEN  PC of in_inst.
- out_valid  out  1  head entry is issuable.
- out_ready  in  1  decode accepts the head entry.
- out_inst  out  32  head instruction word.
- out_pc  out  XLEN  head PC.
- out_illegal  out  1  head pre-decode flagged the instruction illegal.
- out_cflow  out  1  head is JAL, JALR or BRANCH.
- out_serial  out  1  head is a serialising instruction.
- flush  in  1  discard all entries; has priority over everything else.
- pipe_empty  in  1  no instruction in flight downstream of decode.
- count  out  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Reset (asynchronous, active-high):
  - rd_ptr, wr_ptr and count are 0.
  - FSM is in RUN.
  - out_valid is 0.
  - in_ready is 1 from the first cycle after reset deasserts.
- Storage:
  - DEPTH-entry register array, pointers $clog2(DEPTH) bits wide, natural wrap.
  - full = (count == DEPTH); empty = (count == 0).
- Push:
  - in_ready = !full && !flush. No bypass: a push while full is refused even when a pop occurs in the same cycle.
  - push = in_valid && in_ready. On push, write the entry at wr_ptr, then increment wr_ptr.
- Pop:
  - pop = out_valid && out_ready. On pop, increment rd_ptr.
  - count goes +1, −1 or unchanged accordingly; a push and pop in the same cycle leave it unchanged.
- Head outputs:
  - out_inst, out_pc, out_illegal, out_cflow and out_serial are driven combinationally from entry[rd_ptr].
  - When empty they show the stale entry; they are only meaningful while out_valid = 1.
- Pre-decode, computed at write time from in_inst:
  - illegal = (inst[1:0] != 2'b11) OR opcode[6:0] not in {0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011}.
  - cflow = opcode in {1101111, 1100111, 1100011}.
  - serial = (opcode == 1110011) OR (opcode == 0001111 AND funct3 == 3'b001).
  - An illegal entry never has serial = 1; illegal instructions issue normally so decode can raise the trap.
- Serialisation FSM (SERIALIZE = 1); states RUN, DRAIN_PRE, ISSUE, DRAIN_POST:
  - RUN:
    - out_valid = !empty && !head.serial.
    - If !empty && head.serial and pipe_empty = 1, go to ISSUE.
    - If !empty && head.serial and pipe_empty = 0, go to DRAIN_PRE.
  - DRAIN_PRE: out_valid = 0. Go to ISSUE on the first cycle with pipe_empty = 1.
  - ISSUE: out_valid = 1, holding the serial head. On pop, go to DRAIN_POST.
  - DRAIN_POST:
    - out_valid = 0; further pushes are allowed.
    - Go to RUN when pipe_empty = 1. pipe_empty is sampled starting the cycle after the pop, so the serial instruction itself counts as in flight.
  - Transitions are registered, so out_valid for a serial head asserts no earlier than one cycle after it reaches the head.
- SERIALIZE = 0: the FSM stays in RUN and out_valid = !empty.
- Flush:
  - On the clock edge with flush = 1: rd_ptr = wr_ptr = 0, count = 0, FSM goes to RUN.
  - Any push or pop in that same cycle is suppressed: in_ready = 0, and out_valid is forced to 0 combinationally.
  - Flush from any FSM state, including ISSUE, discards the serial instruction.
- Reset mid-operation: asynchronously returns to the reset state; contents are discarded.

Test Plan:
- Fill and drain: reset, then push 4 OP instructions (0x00000033, pc 0x100..0x10C) with out_ready = 0.
  - count reaches 4 and in_ready = 0 at count 4.
  - Then out_ready = 1: 4 pops in PC order, count returns to 0.
  - Wrap-around: push 6 more and pop continuously; order is preserved across the pointer wrap.
- Pre-decode: push 0x00000000, 0x0000006F, 0x30001073, 0x0000100F, 0x0000007F.
  - Head flags {illegal, cflow, serial}: 0x00000000 = {1,0,0}; 0x0000006F = {0,1,0}; 0x30001073 = {0,0,1}; 0x0000100F = {0,0,1}; 0x0000007F = {1,0,0}.
- Serial pre-drain: push csrrw 0x30001073 with pipe_empty = 0 for 3 cycles, then 1.
  - out_valid stays 0 until the cycle after pipe_empty rises.
  - Pop; a following ADD stays blocked until pipe_empty = 1 again.
- Full with simultaneous pop: with count = 4, in_valid = 1 and pop = 1.
  - in_ready = 0 and count goes to 3.
  - The next cycle the push is accepted, so count stays 3 with a concurrent pop or goes to 4 without one.
- Flush: in ISSUE with count = 3, assert flush with in_valid = 1.
  - Next cycle count = 0, FSM is RUN, out_valid = 0, and the flushed-cycle push was not stored.
- SERIALIZE = 0 build: a CSR instruction issues the cycle after push regardless of pipe_empty; async reset mid-stream gives count = 0 immediately.

Source files
------------

// File: rtl/decode_buffer_if.sv
// Fetch-to-decode buffer bus: fetch push side, decode issue side, plus flush and
// pipeline-empty status.
interface decode_buffer_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_pc;
  logic            out_illegal;
  logic            out_cflow;
  logic            out_serial;
  logic            flush;
  logic            pipe_empty;
  logic [CW-1:0]   count;

  modport master (
    output in_valid, in_inst, in_pc, out_ready, flush, pipe_empty,
    input  in_ready, out_valid, out_inst, out_pc, out_illegal, out_cflow, out_serial, count
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready, flush, pipe_empty,
    output in_ready, out_valid, out_inst, out_pc, out_illegal, out_cflow, out_serial, count
  );
endinterface

// File: rtl/decode_buffer.sv
// Instruction buffer between fetch and decode: pre-decodes on entry and holds
// serialising instructions until the downstream pipeline has drained.
module decode_buffer #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned SERIALIZE = 1
) (
  input  logic           clk,
  input  logic           reset,
  decode_buffer_if.slave bus
);
  localparam int unsigned PW     = $clog2(DEPTH);
  localparam int unsigned CW     = $clog2(DEPTH + 1);
  localparam bit          SER_EN = (SERIALIZE != 0);

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic            illegal;
    logic            cflow;
    logic            serial;
  } entry_t;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    DRAIN_PRE  = 2'd1,
    ISSUE      = 2'd2,
    DRAIN_POST = 2'd3
  } state_t;

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  state_t        r_state;
  state_t        w_state_nxt;
  entry_t        w_head;
  entry_t        w_new;
  logic          w_full;
  logic          w_empty;
  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_push;
  logic          w_pop;

  // Pre-decode of the incoming word; every legal opcode ends in 2'b11
  always_comb begin
    w_new         = '0;
    w_new.inst    = bus.in_inst;
    w_new.pc      = bus.in_pc;
    w_new.illegal = 1'b1;
    case (bus.in_inst[6:0])
      7'b0110111, 7'b0010111, 7'b0000011, 7'b0100011,
      7'b0010011, 7'b0110011: w_new.illegal = 1'b0;
      7'b1101111, 7'b1100111, 7'b1100011: begin
        w_new.illegal = 1'b0;
        w_new.cflow   = 1'b1;
      end
      7'b0001111: begin
        w_new.illegal = 1'b0;
        w_new.serial  = (bus.in_inst[14:12] == 3'b001);
      end
      7'b1110011: begin
        w_new.illegal = 1'b0;
        w_new.serial  = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_in_ready = !w_full && !bus.flush;
  assign w_push     = bus.in_valid && w_in_ready;
  assign w_pop      = w_out_valid && bus.out_ready;

  // Serialisation next-state and issue gating
  always_comb begin
    w_state_nxt = r_state;
    w_out_valid = 1'b0;
    if (!SER_EN) begin
      w_state_nxt = RUN;
      w_out_valid = !w_empty;
    end else begin
      case (r_state)
        RUN: begin
          w_out_valid = !w_empty && !w_head.serial;
          if (!w_empty && w_head.serial)
            w_state_nxt = bus.pipe_empty ? ISSUE : DRAIN_PRE;
        end
        DRAIN_PRE: if (bus.pipe_empty) w_state_nxt = ISSUE;
        ISSUE: begin
          w_out_valid = 1'b1;
          if (bus.out_ready) w_state_nxt = DRAIN_POST;
        end
        DRAIN_POST: if (bus.pipe_empty) w_state_nxt = RUN;
        default: w_state_nxt = RUN;
      endcase
    end
    if (bus.flush) begin
      w_out_valid = 1'b0;
      w_state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= RUN;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_state  <= RUN;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  // Payload storage carries no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_new;
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_inst    = w_head.inst;
  assign bus.out_pc      = w_head.pc;
  assign bus.out_illegal = w_head.illegal;
  assign bus.out_cflow   = w_head.cflow;
  assign bus.out_serial  = w_head.serial;
  assign bus.count       = r_count;
endmodule

// File: tb/tb_decode_buffer.sv
// Self-checking bench for decode_buffer: directed scenarios plus random traffic,
// all checked against a queue-based reference model.
module tb_decode_buffer;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [2:0]  flags;  // {illegal, cflow, serial}
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  logic rst0;

  decode_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus  ();
  decode_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus0 ();

  decode_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .SERIALIZE(1)) dut (
    .clk(clk), .reset(rst), .bus(bus)
  );
  decode_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .SERIALIZE(0)) dut0 (
    .clk(clk), .reset(rst0), .bus(bus0)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of entries, plus "serial head has seen an empty
  // pipe" and "waiting for a retired serial instruction to drain"
  ent_t q[$];
  bit   seen;
  bit   post;

  logic        obs_valid;
  logic        obs_ready;
  logic [2:0]  obs_count;
  logic [2:0]  obs_flags;
  logic [31:0] obs_pc;

  logic [31:0] pd_inst  [5] = '{32'h00000000, 32'h0000006F, 32'h30001073, 32'h0000100F, 32'h0000007F};
  logic [2:0]  pd_flags [5] = '{3'b100, 3'b010, 3'b001, 3'b001, 3'b100};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] pdec(input logic [31:0] i);
    logic [6:0] op;
    logic il, cf, se;
    op = i[6:0];
    il = (i[1:0] != 2'b11) || !(op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                           7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                                           7'b0110011, 7'b0001111, 7'b1110011});
    cf = op inside {7'b1101111, 7'b1100111, 7'b1100011};
    se = !il && ((op == 7'b1110011) || (op == 7'b0001111 && i[14:12] == 3'b001));
    return {il, cf, se};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0:       return {r[31:7], 7'b0110011};
      1:       return {r[31:7], 7'b1100011};
      2:       return {r[31:15], 3'b010, r[11:7], 7'b1110011};
      3:       return {r[31:15], 3'b001, r[11:7], 7'b0001111};
      4:       return {r[31:7], 7'b0010011};
      default: return r;
    endcase
  endfunction

  // One clock: check outputs at the falling edge, advance the model at the rising edge
  task automatic cycle();
    logic er, ev, push, pop, old_post;
    ent_t e;
    @(negedge clk);
    er = (q.size() < DEPTH) && !bus.flush;
    ev = !bus.flush && (q.size() > 0) && !post && (!q[0].flags[0] || seen);
    obs_valid = bus.out_valid;
    obs_ready = bus.in_ready;
    obs_count = bus.count;
    obs_flags = {bus.out_illegal, bus.out_cflow, bus.out_serial};
    obs_pc    = bus.out_pc;
    chk("in_ready",  64'(bus.in_ready),  64'(er));
    chk("out_valid", 64'(bus.out_valid), 64'(ev));
    chk("count",     64'(bus.count),     64'(q.size()));
    if (ev) begin
      chk("out_inst",  64'(bus.out_inst), 64'(q[0].inst));
      chk("out_pc",    64'(bus.out_pc),   64'(q[0].pc));
      chk("out_flags", 64'(obs_flags),    64'(q[0].flags));
    end
    @(posedge clk);
    push     = bus.in_valid && er;
    pop      = ev && bus.out_ready;
    old_post = post;
    if (bus.flush) begin
      q.delete();
      seen = 1'b0;
      post = 1'b0;
    end else begin
      if (old_post && bus.pipe_empty) post = 1'b0;
      if (pop) begin
        e    = q.pop_front();
        seen = 1'b0;
        if (e.flags[0]) post = 1'b1;
      end else if (!old_post && q.size() > 0 && q[0].flags[0] && bus.pipe_empty) begin
        seen = 1'b1;
      end
      if (push) begin
        e.inst  = bus.in_inst;
        e.pc    = bus.in_pc;
        e.flags = pdec(bus.in_inst);
        q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic flush_cycle();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    cycle();
    bus.flush    = 1'b0;
  endtask

  task automatic push_one(input logic [31:0] inst, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_inst  = inst;
    bus.in_pc    = pc;
    cycle();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bit found;
    rst  = 1'b1;
    rst0 = 1'b1;
    bus.in_valid = 1'b0;  bus.in_inst = '0;  bus.in_pc = '0;  bus.out_ready = 1'b0;
    bus.flush    = 1'b0;  bus.pipe_empty = 1'b1;
    bus0.in_valid = 1'b0; bus0.in_inst = '0; bus0.in_pc = '0; bus0.out_ready = 1'b0;
    bus0.flush    = 1'b0; bus0.pipe_empty = 1'b0;
    seen = 1'b0;
    post = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    rst0 = 1'b0;
    @(negedge clk);
    chk("rst_count",     64'(bus.count),     64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    @(posedge clk);
    #1;

    // Fill and drain, then wrap the pointers
    for (int i = 0; i < 4; i++) push_one(32'h00000033, 32'h100 + 32'(4 * i));
    cycle();
    chk("fill_count", 64'(obs_count), 64'd4);
    chk("fill_ready", 64'(obs_ready), 64'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("drain_pc", 64'(obs_pc), 64'(32'h100 + 32'(4 * i)));
    end
    cycle();
    chk("drain_count", 64'(obs_count), 64'd0);
    for (int i = 0; i < 6; i++) push_one(32'h00000033, 32'h200 + 32'(4 * i));
    repeat (4) cycle();
    chk("wrap_count", 64'(obs_count), 64'd0);

    // Pre-decode flags observed on issue
    bus.pipe_empty = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_one(pd_inst[i], 32'h280 + 32'(4 * i));
      found = 1'b0;
      for (int k = 0; k < 8 && !found; k++) begin
        cycle();
        if (obs_valid) begin
          found = 1'b1;
          chk("pdec_flags", 64'(obs_flags), 64'(pd_flags[i]));
        end
      end
      chk("pdec_issued", 64'(found), 64'd1);
      cycle();
    end

    // Serial pre-drain and post-drain
    flush_cycle();
    bus.out_ready  = 1'b1;
    bus.pipe_empty = 1'b0;
    push_one(32'h30001073, 32'h300);
    repeat (3) begin
      cycle();
      chk("sp_wait", 64'(obs_valid), 64'd0);
    end
    bus.pipe_empty = 1'b1;
    cycle();
    chk("sp_rise", 64'(obs_valid), 64'd0);
    bus.pipe_empty = 1'b0;
    push_one(32'h00000033, 32'h304);
    chk("sp_issue",        64'(obs_valid), 64'd1);
    chk("sp_issue_serial", 64'(obs_flags), 64'd1);
    repeat (2) begin
      cycle();
      chk("sp_post_block", 64'(obs_valid), 64'd0);
    end
    bus.pipe_empty = 1'b1;
    cycle();
    chk("sp_post_rise", 64'(obs_valid), 64'd0);
    cycle();
    chk("sp_add_issue", 64'(obs_valid), 64'd1);
    chk("sp_add_pc",    64'(obs_pc),    64'h304);

    // Full with simultaneous pop: no bypass
    flush_cycle();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_one(32'h00000033, 32'h400 + 32'(4 * i));
    bus.in_valid = 1'b1; bus.in_inst = 32'h00000033; bus.in_pc = 32'h410; bus.out_ready = 1'b1;
    cycle();
    chk("full_ready", 64'(obs_ready), 64'd0);
    chk("full_count", 64'(obs_count), 64'd4);
    bus.out_ready = 1'b0;
    cycle();
    chk("full_after_pop", 64'(obs_count), 64'd3);
    chk("full_reaccept",  64'(obs_ready), 64'd1);
    bus.in_valid = 1'b0;
    cycle();
    chk("full_refill", 64'(obs_count), 64'd4);

    // Flush while a serial instruction is in ISSUE
    flush_cycle();
    bus.out_ready  = 1'b0;
    bus.pipe_empty = 1'b1;
    push_one(32'h30001073, 32'h500);
    push_one(32'h00000033, 32'h504);
    push_one(32'h00000033, 32'h508);
    chk("fl_issue", 64'(obs_valid), 64'd1);
    bus.in_valid = 1'b1; bus.in_inst = 32'h00000033; bus.in_pc = 32'h50C; bus.flush = 1'b1;
    cycle();
    chk("fl_valid_forced", 64'(obs_valid), 64'd0);
    chk("fl_ready_forced", 64'(obs_ready), 64'd0);
    chk("fl_count_before", 64'(obs_count), 64'd3);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    cycle();
    chk("fl_count", 64'(obs_count), 64'd0);
    chk("fl_valid", 64'(obs_valid), 64'd0);
    bus.pipe_empty = 1'b0;
    push_one(32'h00000033, 32'h600);
    bus.out_ready = 1'b1;
    cycle();
    chk("fl_run_issue", 64'(obs_valid), 64'd1);
    chk("fl_run_pc",    64'(obs_pc),    64'h600);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      bus.in_valid   = ($urandom_range(0, 9) < 7);
      bus.in_inst    = rand_inst();
      bus.in_pc      = $urandom;
      bus.out_ready  = ($urandom_range(0, 9) < 7);
      bus.pipe_empty = 1'($urandom_range(0, 1));
      bus.flush      = ($urandom_range(0, 49) == 0);
      cycle();
    end
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;

    // SERIALIZE = 0 build: serial issues regardless of pipe_empty; async reset
    bus0.in_valid = 1'b1; bus0.in_inst = 32'h30001073; bus0.in_pc = 32'h700;
    @(negedge clk);
    chk("s0_empty_valid", 64'(bus0.out_valid), 64'd0);
    @(posedge clk);
    #1;
    bus0.in_valid = 1'b0;
    @(negedge clk);
    chk("s0_csr_valid",  64'(bus0.out_valid),  64'd1);
    chk("s0_csr_serial", 64'(bus0.out_serial), 64'd1);
    chk("s0_csr_pc",     64'(bus0.out_pc),     64'h700);
    @(posedge clk);
    #1;
    bus0.in_valid = 1'b1; bus0.in_inst = 32'h00000033;
    repeat (2) @(posedge clk);
    #1;
    bus0.in_valid = 1'b0;
    @(negedge clk);
    chk("s0_count", 64'(bus0.count), 64'd3);
    rst0 = 1'b1;
    #1;
    chk("s0_async_rst_count", 64'(bus0.count),     64'd0);
    chk("s0_async_rst_valid", 64'(bus0.out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
